// File: rtl/trap_pkg.sv
// +----------------------------------------------------------------------+
// | trap_pkg                                                             |
// | Shared types and constants for the trap/mret sequencer: FSM state    |
// | encoding, machine-mode CSR addresses, CSR access-type encodings and  |
// | exception cause codes.                                               |
// | Revision: 1.1                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package trap_pkg;

    // T_CAUSE is only reachable when TRAP_MCAUSE_EN is defined.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        T_EPC   = 3'd1,
        T_CAUSE = 3'd2,
        T_VEC   = 3'd3,
        R_EPC   = 3'd4,
        RESP    = 3'd5
    } trap_state_t;

    localparam logic [1:0] CSR_READ_ONLY = 2'd0;
    localparam logic [1:0] CSR_WRITE     = 2'd1;
    localparam logic [1:0] CSR_SET       = 2'd2;
    localparam logic [1:0] CSR_CLEAR     = 2'd3;

    localparam logic [11:0] CSR_ADDR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_ADDR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_ADDR_MTVEC  = 12'h305;

    localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
    localparam logic [3:0] CAUSE_ECALL      = 4'd11;

endpackage

`default_nettype wire

// File: rtl/trap_sequencer.sv
// +----------------------------------------------------------------------+
// | trap_sequencer                                                       |
// | Multi-cycle trap / mret sequencer owning the single CSR file port.   |
// | IDLE and RESP pass pipeline CSR accesses straight through. A trap    |
// | writes mepc (and mcause when TRAP_MCAUSE_EN is defined), reads       |
// | mtvec and redirects; an mret reads mepc and redirects to it.         |
// |                                                                      |
// | Ports:                                                               |
// |   clk, reset            clock, synchronous active-high reset         |
// |   trap_req/cause/pc     trap request, cause code, faulting PC        |
// |   mret_req              mret request                                 |
// |   trap_ack              one-cycle acknowledge (RESP state)           |
// |   redirect_valid/pc     one-cycle redirect pulse and target          |
// |   busy                  sequencer owns the CSR port, pipeline stalls |
// |   pipe_csr_*            pipeline-side CSR access                     |
// |   csr_*                 CSR file side                                |
// |                                                                      |
// | Configuration macro: TRAP_MCAUSE_EN (adds the mcause write state).   |
// | Revision: 1.1                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module trap_sequencer
    import trap_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        trap_req,
    input  logic [3:0]  trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret_req,
    output logic        trap_ack,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    input  logic [11:0] pipe_csr_number,
    input  logic [1:0]  pipe_csr_access_type,
    input  logic [31:0] pipe_csr_in,
    output logic [31:0] pipe_csr_rdata,
    output logic [11:0] csr_number,
    output logic [1:0]  csr_access_type,
    output logic [31:0] csr_in,
    input  logic [31:0] csr_rdata
);

    trap_state_t r_state;
    trap_state_t w_state_nxt;
    logic [31:0] r_redirect_pc;
    logic        w_load_redirect;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. Requests are only looked at in IDLE; trap has
    // priority so a simultaneous mret simply stays pending.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (trap_req) begin
                    w_state_nxt = T_EPC;
                end else if (mret_req) begin
                    w_state_nxt = R_EPC;
                end
            end
`ifdef TRAP_MCAUSE_EN
            T_EPC:   w_state_nxt = T_CAUSE;
            T_CAUSE: w_state_nxt = T_VEC;
`else
            T_EPC:   w_state_nxt = T_VEC;
`endif
            T_VEC:   w_state_nxt = RESP;
            R_EPC:   w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output mux. Pass-through by default; owned states override the port
    // completely so pipeline inputs have no CSR effect while busy.
    always_comb begin
        csr_number      = pipe_csr_number;
        csr_access_type = pipe_csr_access_type;
        csr_in          = pipe_csr_in;
        w_load_redirect = 1'b0;
        case (r_state)
            T_EPC: begin
                csr_number      = CSR_ADDR_MEPC;
                csr_access_type = CSR_WRITE;
                csr_in          = trap_pc;
            end
`ifdef TRAP_MCAUSE_EN
            T_CAUSE: begin
                csr_number      = CSR_ADDR_MCAUSE;
                csr_access_type = CSR_WRITE;
                csr_in          = {28'b0, trap_cause};
            end
`endif
            T_VEC: begin
                csr_number      = CSR_ADDR_MTVEC;
                csr_access_type = CSR_READ_ONLY;
                csr_in          = 32'b0;
                w_load_redirect = 1'b1;
            end
            R_EPC: begin
                csr_number      = CSR_ADDR_MEPC;
                csr_access_type = CSR_READ_ONLY;
                csr_in          = 32'b0;
                w_load_redirect = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Redirect target: mtvec/mepc with the low two bits forced to zero
    // (mtvec mode bits / alignment). Holds until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect_pc <= 32'b0;
        end else if (w_load_redirect) begin
            r_redirect_pc <= {csr_rdata[31:2], 2'b00};
        end
    end

    // Status outputs decode the state register directly, so they are
    // glitch-free and registered in timing.
    assign trap_ack       = (r_state == RESP);
    assign redirect_valid = (r_state == RESP);
    assign busy           = (r_state != IDLE) && (r_state != RESP);
    assign redirect_pc    = r_redirect_pc;
    assign pipe_csr_rdata = csr_rdata;

    // Bits intentionally not consumed in this configuration.
    logic w_unused;
`ifdef TRAP_MCAUSE_EN
    assign w_unused = ^csr_rdata[1:0];
`else
    assign w_unused = ^{csr_rdata[1:0], trap_cause};
`endif

endmodule

`default_nettype wire

// File: tb/tb_trap_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_trap_sequencer                                                    |
// | Self-checking bench for trap_sequencer with a behavioural CSR file.  |
// | Honours TRAP_MCAUSE_EN for latency and mcause expectations.          |
// | Revision: 1.1                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_trap_sequencer;
    import trap_pkg::*;

`ifdef TRAP_MCAUSE_EN
    localparam int TRAP_LAT = 4;
    localparam int TRAP_WR  = 2;
`else
    localparam int TRAP_LAT = 3;
    localparam int TRAP_WR  = 1;
`endif
    localparam int MRET_LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        trap_req;
    logic [3:0]  trap_cause;
    logic [31:0] trap_pc;
    logic        mret_req;
    logic        trap_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic [11:0] pipe_csr_number;
    logic [1:0]  pipe_csr_access_type;
    logic [31:0] pipe_csr_in;
    logic [31:0] pipe_csr_rdata;
    logic [11:0] csr_number;
    logic [1:0]  csr_access_type;
    logic [31:0] csr_in;
    logic [31:0] csr_rdata;

    trap_sequencer dut (
        .clk                  (clk),
        .reset                (reset),
        .trap_req             (trap_req),
        .trap_cause           (trap_cause),
        .trap_pc              (trap_pc),
        .mret_req             (mret_req),
        .trap_ack             (trap_ack),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .busy                 (busy),
        .pipe_csr_number      (pipe_csr_number),
        .pipe_csr_access_type (pipe_csr_access_type),
        .pipe_csr_in          (pipe_csr_in),
        .pipe_csr_rdata       (pipe_csr_rdata),
        .csr_number           (csr_number),
        .csr_access_type      (csr_access_type),
        .csr_in               (csr_in),
        .csr_rdata            (csr_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural CSR file: combinational read, write/set/clear at the edge.
    logic [31:0] env_mepc   = 32'h0;
    logic [31:0] env_mcause = 32'h0;
    logic [31:0] env_mtvec  = 32'h0;

    function automatic logic [31:0] csr_apply(input logic [31:0] old_v,
                                              input logic [1:0]  typ,
                                              input logic [31:0] din);
        case (typ)
            CSR_WRITE: return din;
            CSR_SET:   return old_v | din;
            CSR_CLEAR: return old_v & ~din;
            default:   return old_v;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            if (csr_number == CSR_ADDR_MEPC)
                env_mepc <= csr_apply(env_mepc, csr_access_type, csr_in);
            if (csr_number == CSR_ADDR_MCAUSE)
                env_mcause <= csr_apply(env_mcause, csr_access_type, csr_in);
            if (csr_number == CSR_ADDR_MTVEC)
                env_mtvec <= csr_apply(env_mtvec, csr_access_type, csr_in);
        end
    end

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_number)
            CSR_ADDR_MEPC:   csr_rdata = env_mepc;
            CSR_ADDR_MCAUSE: csr_rdata = env_mcause;
            CSR_ADDR_MTVEC:  csr_rdata = env_mtvec;
            default:         csr_rdata = 32'h0;
        endcase
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe_idle();
        pipe_csr_number      = 12'h000;
        pipe_csr_access_type = CSR_READ_ONLY;
        pipe_csr_in          = 32'h0;
    endtask

    // One pipeline access while the sequencer is idle.
    task automatic pipe_access(input logic [11:0] num, input logic [1:0] typ, input logic [31:0] din);
        pipe_csr_number      = num;
        pipe_csr_access_type = typ;
        pipe_csr_in          = din;
        step();
        pipe_idle();
    endtask

    // Scoreboard of expected redirects.
    typedef struct {
        logic [31:0] pc;
        int          lat;
        int          writes;
        logic [11:0] wr0_num;
        logic [31:0] wr0_data;
    } exp_t;
    exp_t sb[$];

    // Waits for trap_ack, driving a stray CSR_SET into mtvec on the pipeline
    // whenever busy; counts CSR writes seen on the port meanwhile.
    task automatic wait_ack(input int max_cyc);
        int          cyc = 0;
        int          wr  = 0;
        logic [11:0] wn  = 12'h0;
        logic [31:0] wd  = 32'h0;
        logic        got = 1'b0;
        exp_t        e;
        while (cyc < max_cyc && !got) begin
            step();
            cyc++;
            if (busy) begin
                pipe_csr_number      = CSR_ADDR_MTVEC;
                pipe_csr_access_type = CSR_SET;
                pipe_csr_in          = 32'h5A5A_5A50;
            end else begin
                pipe_idle();
            end
            #1;
            if (csr_access_type != CSR_READ_ONLY) begin
                if (wr == 0) begin
                    wn = csr_number;
                    wd = csr_in;
                end
                wr++;
            end
            if (trap_ack) got = 1'b1;
        end
        pipe_idle();
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_timeout: got no trap_ack expected one within %0d cycles", max_cyc);
        end else if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_ack: got trap_ack expected none");
        end else begin
            e = sb.pop_front();
            check("redirect_pc", redirect_pc, e.pc);
            check("redirect_valid", {31'b0, redirect_valid}, 32'h1);
            check("latency", cyc, e.lat);
            check("csr_writes", wr, e.writes);
            if (e.writes > 0) begin
                check("first_wr_num", {20'b0, wn}, {20'b0, e.wr0_num});
                check("first_wr_data", wd, e.wr0_data);
            end
        end
    endtask

    typedef struct {
        logic        is_mret;
        logic [31:0] pc;
        logic [3:0]  cause;
        logic [31:0] csr_init;  // mtvec for a trap, mepc for an mret
        logic [31:0] exp_pc;
    } vec_t;
    vec_t vt[6];

    initial begin
        logic [31:0] saved_mtvec;
        logic        seen_vec;
        logic        pulsed;

        vt[0] = '{1'b0, 32'h0000_0100, CAUSE_ECALL,      32'h0000_2003, 32'h0000_2000};
        vt[1] = '{1'b0, 32'h8000_0044, CAUSE_ILLEGAL,    32'h0000_1000, 32'h0000_1000};
        vt[2] = '{1'b0, 32'h0000_0004, CAUSE_BREAKPOINT, 32'hFFFF_FFF1, 32'hFFFF_FFF0};
        vt[3] = '{1'b1, 32'h0,         4'd0,             32'h0000_0104, 32'h0000_0104};
        vt[4] = '{1'b1, 32'h0,         4'd0,             32'h8000_0002, 32'h8000_0000};
        vt[5] = '{1'b0, 32'h0000_0200, CAUSE_MISALIGNED, 32'h0000_3001, 32'h0000_3000};

        reset      = 1'b1;
        trap_req   = 1'b0;
        mret_req   = 1'b0;
        trap_cause = 4'd0;
        trap_pc    = 32'h0;
        pipe_idle();
        repeat (3) step();

        check("rst_ack", {31'b0, trap_ack}, 32'h0);
        check("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        reset = 1'b0;
        step();

        // Table-driven traps and mrets.
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            if (vt[i].is_mret) pipe_access(CSR_ADDR_MEPC, CSR_WRITE, vt[i].csr_init);
            else               pipe_access(CSR_ADDR_MTVEC, CSR_WRITE, vt[i].csr_init);
            saved_mtvec = env_mtvec;
            if (vt[i].is_mret) begin
                mret_req = 1'b1;
                e = '{vt[i].exp_pc, MRET_LAT, 0, 12'h0, 32'h0};
            end else begin
                trap_req   = 1'b1;
                trap_pc    = vt[i].pc;
                trap_cause = vt[i].cause;
                e = '{vt[i].exp_pc, TRAP_LAT, TRAP_WR, CSR_ADDR_MEPC, vt[i].pc};
            end
            sb.push_back(e);
            wait_ack(10);
            trap_req = 1'b0;
            mret_req = 1'b0;
            step();
            check("ack_one_cycle", {31'b0, trap_ack}, 32'h0);
            check("busy_after", {31'b0, busy}, 32'h0);
            check("mtvec_guard", env_mtvec, saved_mtvec);
            if (vt[i].is_mret) begin
                check("mepc_kept", env_mepc, vt[i].csr_init);
            end else begin
                check("mepc_written", env_mepc, vt[i].pc);
`ifdef TRAP_MCAUSE_EN
                check("mcause_written", env_mcause, {28'b0, vt[i].cause});
`endif
            end
            step();
            check("redirect_hold", redirect_pc, vt[i].exp_pc);
        end

        // Trap and mret together: trap first, held mret then redirects to new mepc.
        pipe_access(CSR_ADDR_MTVEC, CSR_WRITE, 32'h0000_0500);
        pipe_access(CSR_ADDR_MEPC,  CSR_WRITE, 32'h0000_0999);
        trap_req   = 1'b1;
        mret_req   = 1'b1;
        trap_pc    = 32'h0000_0700;
        trap_cause = CAUSE_ECALL;
        sb.push_back('{32'h0000_0500, TRAP_LAT, TRAP_WR, CSR_ADDR_MEPC, 32'h0000_0700});
        wait_ack(10);
        trap_req = 1'b0;
        step();
        check("both_gap_ack", {31'b0, trap_ack}, 32'h0);
        sb.push_back('{32'h0000_0700, MRET_LAT, 0, 12'h0, 32'h0});
        wait_ack(10);
        mret_req = 1'b0;
        step();
        check("both_idle_busy", {31'b0, busy}, 32'h0);

        // Pipeline CSR_SET to mtvec in IDLE takes effect; read back via pipe.
        pipe_access(CSR_ADDR_MTVEC, CSR_WRITE, 32'h0000_1000);
        pipe_access(CSR_ADDR_MTVEC, CSR_SET,   32'h0000_0030);
        check("idle_set_mtvec", env_mtvec, 32'h0000_1030);
        pipe_csr_number = CSR_ADDR_MTVEC;
        #1;
        check("pipe_rdata", pipe_csr_rdata, 32'h0000_1030);
        check("passthru_num", {20'b0, csr_number}, {20'b0, CSR_ADDR_MTVEC});
        pipe_idle();

        // Reset asserted while in T_VEC.
        trap_req   = 1'b1;
        trap_pc    = 32'h0000_0ABC;
        trap_cause = CAUSE_ILLEGAL;
        seen_vec   = 1'b0;
        for (int c = 0; c < 6 && !seen_vec; c++) begin
            step();
            if (busy && csr_number == CSR_ADDR_MTVEC) seen_vec = 1'b1;
        end
        check("reached_t_vec", {31'b0, seen_vec}, 32'h1);
        reset    = 1'b1;
        trap_req = 1'b0;
        step();
        check("rst_mid_busy", {31'b0, busy}, 32'h0);
        check("rst_mid_ack", {31'b0, trap_ack}, 32'h0);
        check("rst_mid_redirect_pc", redirect_pc, 32'h0);
        reset  = 1'b0;
        pulsed = redirect_valid;
        for (int c = 0; c < 5; c++) begin
            step();
            pulsed = pulsed | redirect_valid | trap_ack | busy;
        end
        check("rst_mid_no_pulse", {31'b0, pulsed}, 32'h0);
        check("rst_mid_mepc_kept", env_mepc, 32'h0000_0ABC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1);
    end

endmodule

`default_nettype wire
